// File: rtl/rice_inverse_preprocessor.sv
// rtl/rice_inverse_preprocessor.sv - CCSDS 121.0 inverse mapper with unit-delay predictor
// Rebuilds N-bit samples from mapped residuals and tags reference / block / interval boundaries.
module rice_inverse_preprocessor #(
  parameter int N          = 16,
  parameter int J          = 16,
  parameter int REF_BLOCKS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_delta,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sample,
  output logic         out_ref,
  output logic         out_blk_last,
  output logic         out_rsi_last,
  output logic         busy
);

  localparam int SW = (J > 1) ? $clog2(J) : 1;
  localparam int BW = (REF_BLOCKS > 1) ? $clog2(REF_BLOCKS) : 1;
  localparam logic [N-1:0] XMAX = {N{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state, state_next;
  logic [N-1:0]    xp;
  logic [SW-1:0]   samp_cnt;
  logic [BW-1:0]   blk_cnt;

  logic            in_xfer, out_xfer;
  logic            is_ref, samp_max, blk_max;
  logic [N-1:0]    xp_comp, theta, half, err, x;
  logic [N:0]      two_theta;
  logic            low_side;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE:  if (start) state_next = RUN;
      RUN: begin
        in_ready = start & (~out_valid | out_ready);
        if (!start) state_next = DRAIN;
      end
      DRAIN: if (!out_valid || out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign busy     = (state == RUN) | out_valid;

  assign samp_max = (samp_cnt == SW'(J - 1));
  assign blk_max  = (blk_cnt == BW'(REF_BLOCKS - 1));
  assign is_ref   = (samp_cnt == '0) && (blk_cnt == '0);

  // Sum is taken modulo 2^N: identical to the N+2-bit signed result truncated to N bits.
  always_comb begin
    xp_comp   = XMAX - xp;
    low_side  = (xp <= xp_comp);
    theta     = low_side ? xp : xp_comp;
    two_theta = {theta, 1'b0};
    half      = {1'b0, in_delta[N-1:1]};
    err       = '0;
    if ({1'b0, in_delta} <= two_theta) begin
      if (!in_delta[0]) err = half;
      else              err = '0 - (half + 1'b1);
    end else if (low_side) begin
      err = in_delta - theta;
    end else begin
      err = theta - in_delta;
    end
    x = is_ref ? in_delta : (xp + err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xp       <= '0;
      samp_cnt <= '0;
      blk_cnt  <= '0;
    end else if (state == IDLE && start) begin
      xp       <= '0;
      samp_cnt <= '0;
      blk_cnt  <= '0;
    end else if (in_xfer) begin
      xp <= x;
      if (samp_max) begin
        samp_cnt <= '0;
        blk_cnt  <= blk_max ? '0 : blk_cnt + 1'b1;
      end else begin
        samp_cnt <= samp_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_sample   <= '0;
      out_ref      <= 1'b0;
      out_blk_last <= 1'b0;
      out_rsi_last <= 1'b0;
    end else if (in_xfer) begin
      out_valid    <= 1'b1;
      out_sample   <= x;
      out_ref      <= is_ref;
      out_blk_last <= samp_max;
      out_rsi_last <= samp_max & blk_max;
    end else if (out_xfer) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rice_inverse_preprocessor.sv
// tb/tb_rice_inverse_preprocessor.sv - directed self-checking bench for rice_inverse_preprocessor
module tb_rice_inverse_preprocessor;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_delta, out_sample;
  logic        out_ref, out_blk_last, out_rsi_last, busy;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] din [0:255];
  logic [18:0] obs [0:1023];
  int          obs_cnt = 0;
  int          base;

  rice_inverse_preprocessor #(.N(16), .J(16), .REF_BLOCKS(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_delta(in_delta),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .out_ref(out_ref), .out_blk_last(out_blk_last), .out_rsi_last(out_rsi_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every output transfer as {sample, ref, blk_last, rsi_last}.
  always @(negedge clk) begin
    if (out_valid && out_ready && obs_cnt < 1024) begin
      obs[obs_cnt] <= {out_sample, out_ref, out_blk_last, out_rsi_last};
      obs_cnt      <= obs_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Called just after a rising edge; leaves the bench just after a rising edge.
  task automatic send(input int n);
    int   i = 0;
    int   guard = 0;
    logic acc;
    while (i < n && guard < 2000) begin
      in_valid = 1'b1;
      in_delta = din[i];
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    if (i < n) check("send_timeout", i, n);
  endtask

  task automatic restart();
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_delta = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_sample", out_sample, 0);
    check("rst_flags", {out_ref, out_blk_last, out_rsi_last}, 0);

    // Test 1: 1000 (ref), 4, 5 -> 1000, 1002, 999 with one-cycle latency
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("t1_busy", busy, 1);
    in_valid = 1'b1; in_delta = 16'd1000;
    @(negedge clk); check("t1_in_ready", in_ready, 1);
    @(posedge clk); #1 in_delta = 16'd4;
    @(negedge clk); check("t1_s0", {out_valid, out_ref, out_sample}, {1'b1, 1'b1, 16'd1000});
    @(posedge clk); #1 in_delta = 16'd5;
    @(negedge clk); check("t1_s1", {out_valid, out_ref, out_sample}, {1'b1, 1'b0, 16'd1002});
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check("t1_s2", {out_valid, out_ref, out_sample}, {1'b1, 1'b0, 16'd999});
    @(posedge clk); #1;
    @(negedge clk); check("t1_empty", out_valid, 0);
    @(posedge clk); #1;

    // Test 2: low edge
    restart();
    base = obs_cnt;
    din[0] = 16'd3; din[1] = 16'd10;
    send(2); settle();
    check("t2_cnt", obs_cnt - base, 2);
    check("t2_ref", obs[base][18:3], 3);
    check("t2_x", obs[base+1][18:2], {16'd10, 1'b0});

    // Test 3: high edge
    restart();
    base = obs_cnt;
    din[0] = 16'd65533; din[1] = 16'd9;
    send(2); settle();
    check("t3_ref", obs[base][18:2], {16'd65533, 1'b1});
    check("t3_x", obs[base+1][18:2], {16'd65526, 1'b0});

    // Test 4: backpressure for 3 cycles mid-stream
    restart();
    base = obs_cnt;
    din[0] = 16'd1000; din[1] = 16'd4; din[2] = 16'd5; din[3] = 16'd2; din[4] = 16'd3;
    fork
      send(5);
      begin
        repeat (2) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("t4_stall_in_ready", in_ready, 0);
          check("t4_stall_hold", {out_valid, out_sample}, {1'b1, 16'd1002});
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    settle();
    check("t4_cnt", obs_cnt - base, 5);
    check("t4_s0", obs[base][18:3], 1000);
    check("t4_s1", obs[base+1][18:3], 1002);
    check("t4_s2", obs[base+2][18:3], 999);
    check("t4_s3", obs[base+3][18:3], 1000);
    check("t4_s4", obs[base+4][18:3], 998);

    // Test 5: 128 samples across block and reference-interval boundaries
    restart();
    base = obs_cnt;
    din[0] = 16'd500;
    for (int i = 1; i < 128; i++) din[i] = 16'd0;
    send(128); settle();
    check("t5_cnt", obs_cnt - base, 128);
    for (int i = 0; i < 128; i++) begin
      check($sformatf("t5_s%0d", i), obs[base+i],
            {(i < 64) ? 16'd500 : 16'd0, (i % 64) == 0, (i % 16) == 15, (i % 64) == 63});
    end

    // Test 6: asynchronous reset while an output is pending
    restart();
    din[0] = 16'd42;
    out_ready = 1'b0;
    send(1);
    check("t6_pending", out_valid, 1);
    #1 reset = 1'b0;
    #1;
    check("t6_async_clear", {out_valid, out_sample}, 0);
    @(posedge clk); #1;
    reset = 1'b1; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    din[0] = 16'd777;
    send(1);
    @(negedge clk);
    check("t6_first", {out_valid, out_ref, out_sample}, {1'b1, 1'b1, 16'd777});
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
